// File: rtl/qspi_ram_responder_if.sv
// qspi_ram_responder_if: quad-SPI pin bundle between the initiator (master) and the RAM responder (slave).
interface qspi_ram_responder_if;
  logic       spi_clk_in;
  logic       spi_select_n;
  logic [3:0] spi_data_in;
  logic [3:0] spi_data_out;
  logic [3:0] spi_data_oe;
  modport master (output spi_clk_in, spi_select_n, spi_data_in, input spi_data_out, spi_data_oe);
  modport slave (input spi_clk_in, spi_select_n, spi_data_in, output spi_data_out, spi_data_oe);
endinterface

// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder: oversampled quad-SPI PSRAM stand-in serving 0xEB reads / 0x38 writes from a byte array.
// Defining QSPI_RESP_STATUS_EN adds the saturating wr_count port and the 0x05 status-read command.
module qspi_ram_responder #(
  parameter int ADDR_BITS    = 7,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  qspi_ram_responder_if.slave   spi,
  output logic                  busy
`ifdef QSPI_RESP_STATUS_EN
  , output logic [7:0]          wr_count
`endif
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;
  state_t                state;
  logic [5:0]            s1, s2;
  logic                  clk_q, sel_q, ph, wr;
  logic [7:0]            cnt;
  logic [3:0]            hold;
  logic [ADDR_BITS-1:0]  addr;
  logic [7:0]            mem [2**ADDR_BITS];
  logic                  clk_s, sel_s, qual, rise, fall, we;
  logic [3:0]            nib;
  logic [7:0]            rd_byte;
`ifdef QSPI_RESP_STATUS_EN
  logic                  stat;
  assign rd_byte = stat ? wr_count : mem[addr];
`else
  assign rd_byte = mem[addr];
`endif
  assign clk_s = s2[5];
  assign sel_s = s2[4];
  assign nib   = s2[3:0];
  assign qual  = ~sel_s & ~sel_q;
  assign rise  = qual & clk_s & ~clk_q;
  assign fall  = qual & ~clk_s & clk_q;
  assign we    = (state == WDATA) && rise && ph;
  // Select syncs reset low so a select already held low at release never looks like a fall.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      clk_q <= 1'b0;
      sel_q <= 1'b0;
    end else begin
      s1    <= {spi.spi_clk_in, spi.spi_select_n, spi.spi_data_in};
      s2    <= s1;
      clk_q <= s2[5];
      sel_q <= s2[4];
    end
  always_ff @(posedge clk)
    if (we) mem[addr] <= {hold, nib};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      hold             <= '0;
      addr             <= '0;
      ph               <= 1'b0;
      wr               <= 1'b0;
      busy             <= 1'b0;
      spi.spi_data_out <= '0;
      spi.spi_data_oe  <= '0;
`ifdef QSPI_RESP_STATUS_EN
      stat             <= 1'b0;
      wr_count         <= '0;
`endif
    end else begin
      busy <= ~sel_s;
      if (sel_s) begin
        state           <= IDLE;
        spi.spi_data_oe <= '0;
      end else case (state)
        IDLE: if (sel_q) begin
          state <= CMD;
          ph    <= 1'b0;
`ifdef QSPI_RESP_STATUS_EN
          stat  <= 1'b0;
`endif
        end
        CMD: if (rise) begin
          hold <= nib;
          ph   <= 1'b1;
          if (ph) begin
            if ({hold, nib} == 8'hEB || {hold, nib} == 8'h38) begin
              state <= ADDR;
              wr    <= ({hold, nib} == 8'h38);
              cnt   <= '0;
            end
`ifdef QSPI_RESP_STATUS_EN
            else if ({hold, nib} == 8'h05) begin
              state <= RDATA;
              stat  <= 1'b1;
              ph    <= 1'b0;
            end
`endif
            else state <= IGNORE;
          end
        end
        ADDR: if (rise) begin
          addr <= ADDR_BITS'({addr, nib});
          cnt  <= cnt + 8'd1;
          if (cnt == 8'd5) begin
            ph    <= 1'b0;
            cnt   <= '0;
            state <= wr ? WDATA : (DUMMY_CYCLES == 0 ? RDATA : DUMMY);
          end
        end
        DUMMY: if (rise) begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'(DUMMY_CYCLES - 1)) state <= RDATA;
        end
        RDATA: if (fall) begin
          spi.spi_data_oe  <= 4'hF;
          spi.spi_data_out <= ph ? rd_byte[3:0] : rd_byte[7:4];
          ph               <= ~ph;
          if (ph) addr <= addr + 1'b1;
        end
        WDATA: if (rise) begin
          ph <= ~ph;
          if (!ph) hold <= nib;
          else begin
            addr <= addr + 1'b1;
`ifdef QSPI_RESP_STATUS_EN
            if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
`endif
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_qspi_ram_responder.sv
// tb_qspi_ram_responder: bit-bangs quad-SPI transactions and scoreboards read nibbles against a byte-array model.
module tb_qspi_ram_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  qspi_ram_responder_if bus();
`ifdef QSPI_RESP_STATUS_EN
  logic [7:0] wr_count;
  qspi_ram_responder dut (.clk(clk), .rst_n(rst_n), .spi(bus), .busy(busy), .wr_count(wr_count));
`else
  qspi_ram_responder dut (.clk(clk), .rst_n(rst_n), .spi(bus), .busy(busy));
`endif
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int wr_m = 0;
  logic [7:0] mem_m [128];
  logic [3:0] exp_q [$];

  task automatic xfer(input logic [3:0] n, output logic [3:0] o, output logic [3:0] oe);
    bus.spi_data_in = n;
    repeat (6) @(negedge clk);
    o  = bus.spi_data_out;
    oe = bus.spi_data_oe;
    bus.spi_clk_in = 1'b1;
    repeat (6) @(negedge clk);
    bus.spi_clk_in = 1'b0;
  endtask

  task automatic begin_tx;
    bus.spi_select_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_tx(input string name);
    repeat (4) @(negedge clk);
    bus.spi_select_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.spi_data_oe !== 4'h0) begin
      errors++;
      $display("FAIL %s deselect_oe: got %h expected 0", name, bus.spi_data_oe);
    end
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
    logic [3:0] o, oe;
    logic [31:0] w;
    w = {cmd, a};
    for (int i = 7; i >= 0; i--) xfer(w[i*4 +: 4], o, oe);
  endtask

  task automatic write_byte(input logic [6:0] a, input logic [7:0] b);
    logic [3:0] o, oe;
    xfer(b[7:4], o, oe);
    xfer(b[3:0], o, oe);
    mem_m[a] = b;
    if (wr_m < 255) wr_m++;
  endtask

  task automatic do_write(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1, input int n);
    begin_tx;
    send_hdr(8'h38, a);
    for (int i = 0; i < n; i++) write_byte(7'(int'(a[6:0]) + i), i == 0 ? b0 : b1);
    end_tx("write");
  endtask

  task automatic drain(input string name);
    logic [3:0] o, oe, e;
    while (exp_q.size() > 0) begin
      xfer(4'h0, o, oe);
      e = exp_q.pop_front();
      checks++;
      if (o !== e || oe !== 4'hF) begin
        errors++;
        $display("FAIL %s data: got %h oe %h expected %h oe f", name, o, oe, e);
      end
    end
  endtask

  task automatic do_read(input logic [23:0] a, input int n, input string name);
    logic [3:0] o, oe;
    logic [7:0] b;
    begin_tx;
    send_hdr(8'hEB, a);
    for (int d = 0; d < 6; d++) xfer(4'h0, o, oe);
    checks++;
    if (oe !== 4'h0) begin
      errors++;
      $display("FAIL %s dummy_oe: got %h expected 0", name, oe);
    end
    for (int i = 0; i < n; i++) begin
      b = mem_m[7'(int'(a[6:0]) + i)];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
    end
    drain(name);
    end_tx(name);
  endtask

  task automatic test_reset;
    checks += 3;
    if (bus.spi_data_oe !== 4'h0) begin errors++; $display("FAIL reset_oe: got %h expected 0", bus.spi_data_oe); end
    if (bus.spi_data_out !== 4'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", bus.spi_data_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_trip;
    do_write(24'h000010, 8'hA5, 8'h3C, 2);
    do_read(24'h000010, 2, "round_trip");
  endtask

  task automatic test_wrap;
    do_write(24'h00007F, 8'h11, 8'h22, 2);
    do_read(24'h000000, 1, "wrap_lo");
    do_read(24'h00007F, 1, "wrap_hi");
  endtask

  task automatic test_partial;
    logic [3:0] o, oe;
    do_write(24'h000005, 8'h77, 8'h00, 1);
    begin_tx;
    send_hdr(8'h38, 24'h000005);
    xfer(4'h9, o, oe);
    end_tx("partial");
    do_read(24'h000005, 1, "partial_read");
  endtask

  task automatic test_unknown;
    logic [3:0] o, oe;
    begin_tx;
    xfer(4'h9, o, oe);
    xfer(4'hF, o, oe);
    for (int i = 0; i < 20; i++) begin
      xfer(4'(i), o, oe);
      checks++;
      if (oe !== 4'h0) begin errors++; $display("FAIL unknown_oe[%0d]: got %h expected 0", i, oe); end
    end
    end_tx("unknown");
    do_read(24'h000010, 2, "after_unknown");
  endtask

  task automatic test_reset_mid_read;
    logic [3:0] o, oe;
    logic [31:0] w;
    begin_tx;
    send_hdr(8'hEB, 24'h000010);
    for (int d = 0; d < 6; d++) xfer(4'h0, o, oe);
    xfer(4'h0, o, oe);
    checks++;
    if (o !== 4'hA || oe !== 4'hF) begin errors++; $display("FAIL midread_first: got %h oe %h expected a oe f", o, oe); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (bus.spi_data_oe !== 4'h0) begin errors++; $display("FAIL midread_rst_oe: got %h expected 0", bus.spi_data_oe); end
    if (bus.spi_data_out !== 4'h0) begin errors++; $display("FAIL midread_rst_out: got %h expected 0", bus.spi_data_out); end
    wr_m = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    w = {8'hEB, 24'h000010};
    for (int i = 0; i < 16; i++) begin
      xfer(i < 8 ? w[(7 - i)*4 +: 4] : 4'h0, o, oe);
      checks++;
      if (oe !== 4'h0) begin errors++; $display("FAIL held_select_oe[%0d]: got %h expected 0", i, oe); end
    end
    end_tx("held_select");
    do_read(24'h000010, 2, "after_reset");
  endtask

`ifdef QSPI_RESP_STATUS_EN
  task automatic status_read(input string name);
    logic [3:0] o, oe;
    logic [7:0] c;
    c = 8'(wr_m);
    begin_tx;
    xfer(4'h0, o, oe);
    xfer(4'h5, o, oe);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(c[7:4]);
      exp_q.push_back(c[3:0]);
    end
    drain(name);
    end_tx(name);
  endtask

  task automatic test_status;
    do_write(24'h000030, 8'h01, 8'h02, 2);
    do_write(24'h000032, 8'h03, 8'h00, 1);
    checks++;
    if (wr_count !== 8'h03) begin errors++; $display("FAIL wr_count_3: got %h expected 03", wr_count); end
    status_read("status_3");
    begin_tx;
    send_hdr(8'h38, 24'h000040);
    for (int i = 0; i < 300; i++) write_byte(7'(8'h40 + i), 8'($urandom));
    end_tx("long_write");
    checks++;
    if (wr_count !== 8'hFF) begin errors++; $display("FAIL wr_count_sat: got %h expected ff", wr_count); end
    status_read("status_sat");
  endtask
`endif

  task automatic test_back_to_back;
    logic [6:0] a;
    for (int k = 0; k < 3; k++) begin
      a = 7'($urandom_range(0, 127));
      do_write({17'h0, a}, 8'($urandom), 8'($urandom), 2);
      do_read({17'h0, a}, 2, "back_to_back");
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.spi_clk_in   = 1'b0;
    bus.spi_select_n = 1'b1;
    bus.spi_data_in  = 4'h0;
    repeat (3) @(negedge clk);
    test_reset;
    test_round_trip;
    test_wrap;
    test_partial;
    test_unknown;
    test_reset_mid_read;
`ifdef QSPI_RESP_STATUS_EN
    test_status;
`endif
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qspi_ram_responder.md
# qspi_ram_responder

Synthesizable QSPI RAM responder: the device end of the quad-SPI link that the SoC memory controller drives as initiator. It decodes quad-mode read/write transactions and serves them from a small internal byte array. It sits on the far side of the `uio` QSPI pins, on a companion tile or FPGA, as a PSRAM stand-in for bring-up and for closed-loop simulation of the controller. All SPI inputs are oversampled on the single system clock; nothing is clocked by the SPI clock.

## Interface

Parameters:
- `ADDR_BITS`, default 7: internal array is 2^ADDR_BITS bytes.
- `DUMMY_CYCLES`, default 6: SPI clocks between the last address nibble and the first read-data nibble.

Ports:
- `clk`  in  1  system clock; every flop is clocked on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `spi_clk_in`  in  1  SPI clock from the initiator; idles low.
- `spi_select_n`  in  1  chip select, active-low.
- `spi_data_in`  in  4  quad data from the initiator.
- `spi_data_out`  out  4  quad read data.
- `spi_data_oe`  out  4  output enables: all ones while driving read data, otherwise all zeros.
- `busy`  out  1  high while a synchronized select is active.
- `wr_count`  out  8  only with `QSPI_RESP_STATUS_EN`: count of committed write bytes.

## Operation

- **Input synchronizer.** `spi_clk_in`, `spi_select_n` and `spi_data_in` each pass through an identical 2-flop synchronizer, so they stay mutually aligned.
- **Edge detection.** A rise or fall is detected from the synchronized clock (current sample versus previous sample).
- **Edge qualification.** An edge counts only when the synchronized select was low in both the previous and the current sample.
- **Wire protocol.** Every field is nibble-wide and most-significant nibble first. Input nibbles are sampled on SPI rising edges. Output nibbles change on SPI falling edges.
- **State machine.** States are IDLE, CMD, ADDR, DUMMY, RDATA, WDATA and IGNORE.
  - IDLE → CMD: synchronized select falls.
  - CMD: collects 2 nibbles.
    - 0xEB (read) or 0x38 (write) → ADDR.
    - 0x05 → RDATA with the status byte (only with `QSPI_RESP_STATUS_EN`).
    - Any other command → IGNORE.
  - ADDR: collects 6 nibbles (24 bits). Only the low ADDR_BITS bits are kept.
    - Read → DUMMY. If DUMMY_CYCLES = 0, go straight to RDATA.
    - Write → WDATA.
  - DUMMY: counts DUMMY_CYCLES rising edges, then → RDATA.
  - RDATA:
    - On the first falling edge in RDATA, assert `spi_data_oe` and drive `mem[addr][7:4]`.
    - On the next falling edge, drive `[3:0]` and increment the address.
    - Repeat for every following byte.
  - WDATA:
    - The first nibble of each pair goes to a holding register.
    - On the second nibble, write the byte to `mem[addr]` and increment the address.
  - IGNORE: no response until deselect.
- **Address arithmetic.** The address increments modulo 2^ADDR_BITS (wraps to 0).
- **Deselect.** A synchronized select high in any state has these effects:
  - the state machine returns to IDLE;
  - `spi_data_oe` goes to 0 on the next clk;
  - a partial write nibble is discarded, and the memory is unchanged for that byte.
- **Reset.** The memory array is not reset.
  - `spi_data_out` = 0, `spi_data_oe` = 0, `busy` = 0 and `wr_count` = 0 immediately on `rst_n` low.
  - The state machine returns to IDLE.
  - After reset release, a select that is already low is ignored until it has gone high once.

## Timing

- Input-to-internal latency is 2 clk (synchronizer) plus 1 clk (edge detect).
- Output nibbles are registered and appear 1 clk after the detected falling edge, i.e. 4 clk after the pin edge.
- SPI clock high and low phases must each be at least 5 clk so that read data is stable at the initiator's next rising edge. Select setup and hold to the SPI clock must each be at least 3 clk.
- A write byte is committed to the array on the same clk that its second nibble's rising edge is detected.
- A read that follows a write to the same address, in a later transaction, returns the new data.

## Configuration

`QSPI_RESP_STATUS_EN`:
- **Defined:**
  - Port `wr_count` exists. It increments by 1 on every committed write byte and saturates at 0xFF.
  - Command 0x05 is decoded: no address, no dummy cycles. From the next falling edge the responder outputs `wr_count` (2 nibbles) and then repeats it until deselect.
- **Undefined:**
  - The port and the counter are absent.
  - 0x05 is treated as an unknown command and goes to IGNORE.

## Test plan

- **Write/read round trip.** Write 0x38, address 0x000010, data 0xA5 0x3C. Then read 0xEB from 0x000010 with 6 dummy clocks. The read returns nibbles A,5,3,C, and `spi_data_oe` = 0xF only during the data phase.
- **Address wrap.** With ADDR_BITS = 7, write 0x11 0x22 starting at 0x7F. Reading at 0x00 returns 0x22 and reading at 0x7F returns 0x11.
- **Partial byte.** Write 0x38 to address 5, send one nibble 0x9, then deselect. A read at 5 returns the prior value, and `spi_data_oe` is 0 within 1 clk of the synchronized deselect.
- **Unknown command.** Command 0x9F followed by 20 clocks. `spi_data_oe` stays 0, memory is unchanged, and the next transaction decodes normally.
- **Reset mid-read.** Assert `rst_n` low during RDATA. `spi_data_oe` = 0 immediately. After release with select still low, there is no response until select has toggled high then low.
- **Status (macro defined).** Write 3 bytes, then send 0x05. The response is 0x03, and the counter holds at 0xFF after 300 writes.
